// File: rtl/sram_ctrl.sv
// MEM-stage controller for a 16-bit asynchronous SRAM: each 32-bit access becomes
// two halfword cycles (high first) plus wait cycles, with ready low while busy.
module sram_ctrl #(
    parameter int          ACCESS_CYCLES = 5,
    parameter logic [31:0] BASE_ADR      = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] adr,
    input  logic [31:0] data_in,
    output logic [31:0] DATA,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ_I,
    output logic [15:0] SRAM_DQ_O,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_WE_N
);

    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WAIT, S_DONE} state_t;

    localparam bit         HAS_WAIT  = (ACCESS_CYCLES > 3);
    // WAIT lasts ACCESS_CYCLES-3 cycles: counter runs 0 .. WAIT_LAST.
    localparam logic [3:0] WAIT_LAST = HAS_WAIT ? 4'(ACCESS_CYCLES - 4) : 4'd0;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [16:0] r_w;
    logic [31:0] r_data;
    logic        r_rd;
    logic [15:0] r_hi_tmp;

    logic        w_req;
    logic [31:0] w_off;
    logic        w_unused;

    assign w_req    = MEM_R_EN | MEM_W_EN;
    assign w_off    = {adr[31:2], 2'b00} - BASE_ADR;
    assign w_unused = ^{w_off[31:19], w_off[1:0], adr[1:0]};

    always_comb begin
        w_next     = r_state;
        ready      = 1'b0;
        SRAM_ADDR  = 18'd0;
        SRAM_DQ_O  = 16'd0;
        SRAM_DQ_OE = 1'b0;
        SRAM_WE_N  = 1'b1;
        case (r_state)
            S_IDLE: begin
                ready = ~w_req;
                if (w_req) w_next = S_HI;
            end
            S_HI: begin
                SRAM_ADDR = {r_w, 1'b0};
                if (!r_rd) begin
                    SRAM_WE_N  = 1'b0;
                    SRAM_DQ_OE = 1'b1;
                    SRAM_DQ_O  = r_data[31:16];
                end
                w_next = S_LO;
            end
            S_LO: begin
                SRAM_ADDR = {r_w, 1'b1};
                if (!r_rd) begin
                    SRAM_WE_N  = 1'b0;
                    SRAM_DQ_OE = 1'b1;
                    SRAM_DQ_O  = r_data[15:0];
                end
                w_next = HAS_WAIT ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                if (r_cnt == WAIT_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                ready  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_w      <= 17'd0;
            r_data   <= 32'd0;
            r_rd     <= 1'b0;
            r_hi_tmp <= 16'd0;
            DATA     <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    // Read wins when both enables are high.
                    if (w_req) begin
                        r_w    <= w_off[18:2];
                        r_data <= data_in;
                        r_rd   <= MEM_R_EN;
                    end
                end
                S_HI: begin
                    if (r_rd) r_hi_tmp <= SRAM_DQ_I;
                end
                S_LO: begin
                    if (r_rd) DATA <= {r_hi_tmp, SRAM_DQ_I};
                    r_cnt <= 4'd0;
                end
                S_WAIT: r_cnt <= r_cnt + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: behavioural SRAM, per-cycle bus/ready checks,
// plus a second instance built with the minimum access length.
module tb_sram_ctrl;
    localparam int          AC   = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, r_en, w_en;
    logic [31:0] adr, din, DATA;
    logic        ready, oe, we_n;
    logic [17:0] addr;
    logic [15:0] dq_i, dq_o;

    logic        r_en3;
    logic [31:0] adr3, DATA3;
    logic        ready3, oe3, we_n3;
    logic [17:0] addr3;
    logic [15:0] dq_i3, dq_o3;

    bit [15:0] sram  [0:262143];
    bit [15:0] sram3 [0:262143];
    assign dq_i  = sram[addr];
    assign dq_i3 = sram3[addr3];
    always @(posedge clk) if (!we_n && oe) sram[addr] <= dq_o;

    sram_ctrl #(.ACCESS_CYCLES(AC), .BASE_ADR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .adr(adr),
        .data_in(din), .DATA(DATA), .ready(ready), .SRAM_ADDR(addr), .SRAM_DQ_I(dq_i),
        .SRAM_DQ_O(dq_o), .SRAM_DQ_OE(oe), .SRAM_WE_N(we_n));

    sram_ctrl #(.ACCESS_CYCLES(3), .BASE_ADR(BASE)) dut3 (
        .clk(clk), .rst_n(rst_n), .MEM_R_EN(r_en3), .MEM_W_EN(1'b0), .adr(adr3),
        .data_in(32'd0), .DATA(DATA3), .ready(ready3), .SRAM_ADDR(addr3), .SRAM_DQ_I(dq_i3),
        .SRAM_DQ_O(dq_o3), .SRAM_DQ_OE(oe3), .SRAM_WE_N(we_n3));

    int nvec = 0, nerr = 0;
    logic [31:0] refm [int];
    logic [31:0] exp_q [$];
    logic [31:0] last_data = 32'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] widx(input logic [31:0] a);
        logic [31:0] o;
        o = {a[31:2], 2'b00} - BASE;
        return o[18:2];
    endfunction

    // Entered just after a rising edge with the DUT in IDLE; returns likewise.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [16:0] w;
        logic [31:0] e;
        w = widx(a);
        r_en = rd; w_en = wr; adr = a; din = d;
        if (rd) exp_q.push_back(refm.exists(int'(w)) ? refm[int'(w)] : 32'd0);
        else    refm[int'(w)] = d;
        for (int c = 0; c <= AC; c++) begin
            @(negedge clk);
            chk("ready", {31'd0, ready}, {31'd0, c == AC});
            if (c == 1 || c == 2) begin
                chk("addr", {14'd0, addr}, {14'd0, w, c == 2});
                chk("we_n", {31'd0, we_n}, {31'd0, rd});
                chk("oe", {31'd0, oe}, {31'd0, !rd});
                if (!rd) chk("dq_o", {16'd0, dq_o}, {16'd0, (c == 1) ? d[31:16] : d[15:0]});
            end else begin
                chk("idle_bus", {14'd0, addr, we_n, oe}, {14'd0, 18'd0, 1'b1, 1'b0});
            end
            if (rd && c == 3) begin
                if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                else last_data = exp_q.pop_front();
            end
            chk("data", DATA, last_data);
            if (c == 1) begin
                adr = ~a; din = ~d;
            end
            @(posedge clk);
        end
        #1 r_en = 1'b0; w_en = 1'b0;
    endtask

    initial begin
        logic [31:0] e3 [0:1];
        rst_n = 1'b0; r_en = 1'b0; w_en = 1'b0; adr = 32'd0; din = 32'd0;
        r_en3 = 1'b0; adr3 = 32'd0;
        sram3[0] = 16'h1111; sram3[1] = 16'h2222; sram3[2] = 16'h3333; sram3[3] = 16'h4444;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, we_n}, 32'd1);
        chk("rst_oe", {31'd0, oe}, 32'd0);
        chk("rst_data", DATA, 32'd0);
        chk("rst_addr", {14'd0, addr}, 32'd0);
        @(posedge clk); #1;

        access(0, 1, 32'd1032, 32'hDEADBEEF);
        chk("sram4", {16'd0, sram[4]}, 32'h0000DEAD);
        chk("sram5", {16'd0, sram[5]}, 32'h0000BEEF);
        access(1, 0, 32'd1035, 32'h0);
        chk("rd_dead", DATA, 32'hDEADBEEF);
        access(1, 1, 32'd1032, 32'h0);
        chk("both_rd", DATA, 32'hDEADBEEF);
        chk("both_nowrite", {sram[4], sram[5]}, 32'hDEADBEEF);
        // back-to-back, including an address that wraps to the last word
        access(0, 1, 32'd1424, 32'h12345678);
        access(0, 1, 32'd1020, 32'hA5A5C3C3);
        access(1, 0, 32'd1424, 32'h0);
        access(1, 0, 32'd1022, 32'h0);
        chk("wrap_hi", {16'd0, sram[18'h3FFFE]}, 32'h0000A5A5);

        // reset in the LO cycle of a write
        r_en = 1'b0; w_en = 1'b1; adr = 32'd1040; din = 32'h0BAD0BAD;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b0; w_en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_ready", {31'd0, ready}, 32'd1);
        chk("mid_we_n", {31'd0, we_n}, 32'd1);
        chk("mid_oe", {31'd0, oe}, 32'd0);
        chk("mid_data", DATA, 32'd0);
        last_data = 32'd0;
        @(posedge clk); #1;
        access(0, 1, 32'd1040, 32'hCAFEF00D);
        access(1, 0, 32'd1040, 32'h0);
        chk("reissue", DATA, 32'hCAFEF00D);

        // minimum-length build: no WAIT, DONE every 4th cycle
        e3[0] = 32'h11112222; e3[1] = 32'h33334444;
        r_en3 = 1'b1; adr3 = 32'd1024;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("r3_ready", {31'd0, ready3}, {31'd0, (c % 4) == 3});
            if ((c % 4) == 1 || (c % 4) == 2)
                chk("r3_addr", {14'd0, addr3}, (c < 4) ? c - 1 : c - 3);
            if ((c % 4) == 3) chk("r3_data", DATA3, e3[c / 4]);
            chk("r3_we_n", {31'd0, we_n3}, 32'd1);
            @(posedge clk);
            if (c == 3) #1 adr3 = 32'd1028;
        end
        #1 r_en3 = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
